inst_issue_ctrl: RTL

Instruction issue controller sitting directly upstream of the single-cycle MIPS core (`SP`). It reads instructions from a synchronous instruction ROM, presents them one at a time on the core's `in_valid`/`inst` handshake, waits for `out_valid`, and adopts the core's returned `inst_addr` as the next fetch PC. It counts retired instructions, flags timeouts and bad PCs, and replaces the bench-driven stimulus when the core runs stand-alone on FPGA.

---
 rtl/sp_pkg.sv | 21 ++
 rtl/issue_lat_timer.sv | 39 +++
 rtl/inst_issue_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// Shared definitions for the SP core, its memory wrapper and the issue controller.
package sp_pkg;

    localparam int unsigned INST_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StWait,
        StDone,
        StErr
    } issue_state_e;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrTimeout  = 2'd1;
    localparam logic [1:0] ErrMisalign = 2'd2;
    localparam logic [1:0] ErrRange    = 2'd3;

endpackage

// File: rtl/issue_lat_timer.sv
// WAIT-state latency counter: cleared in ISSUE, advanced once per WAIT cycle.
module issue_lat_timer #(
    parameter int unsigned MAX_LATENCY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(MAX_LATENCY + 1);

    // cnt_q holds completed WAIT cycles, so the current WAIT cycle number is cnt_q + 1
    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then increment while enabled, parking at MAX_LATENCY
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(MAX_LATENCY))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the MAX_LATENCY-th WAIT cycle
    assign expired_o = en_i && (cnt_q == CW'(MAX_LATENCY - 1));

endmodule

// File: rtl/inst_issue_ctrl.sv
// Instruction issue controller: fetches from a synchronous ROM, hands one instruction
// at a time to the core and follows the core's returned PC.
module inst_issue_ctrl
    import sp_pkg::*;
#(
    parameter int unsigned IMEM_AW     = 10,
    parameter int unsigned MAX_LATENCY = 10,
    parameter int unsigned CNT_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   num_inst_i,
    output logic               imem_rd_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [INST_W-1:0]  imem_rdata_i,
    output logic               in_valid_o,
    output logic [INST_W-1:0]  inst_o,
    input  logic               out_valid_i,
    input  logic [31:0]        inst_addr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [CNT_W-1:0]   retired_o
);

    issue_state_e state_q, state_d;

    // Only the word-address bits of the PC are kept; out-of-range PCs never reach FETCH
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [1:0]         err_code_q, err_code_d;

    logic             start_ok;
    logic             expired;
    logic [CNT_W-1:0] retired_inc;
    logic             addr_misaligned;
    logic             addr_oor;

    assign start_ok        = start_i &&
                             ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    assign retired_inc     = (retired_q == '1) ? retired_q : retired_q + 1'b1;
    assign addr_misaligned = |inst_addr_i[1:0];
    assign addr_oor        = |(inst_addr_i >> (IMEM_AW + 2));

    issue_lat_timer #(
        .MAX_LATENCY (MAX_LATENCY)
    ) u_lat_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == StIssue),
        .en_i      (state_q == StWait),
        .expired_o (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_ok) begin
                    state_d = (num_inst_i == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad:  state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (out_valid_i) begin
                    // Reaching the target wins over a bad returned PC
                    if (retired_inc == target_q) begin
                        state_d = StDone;
                    end else if (addr_misaligned || addr_oor) begin
                        state_d = StErr;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (expired) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: run setup on start, PC/retire/error capture in WAIT
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        retired_d  = retired_q;
        target_d   = target_q;
        err_code_d = err_code_q;
        if (start_ok) begin
            pc_d       = '0;
            retired_d  = '0;
            err_code_d = ErrNone;
            target_d   = num_inst_i;
        end else if (state_q == StLoad) begin
            inst_d = imem_rdata_i;
        end else if (state_q == StWait) begin
            if (out_valid_i) begin
                pc_d      = inst_addr_i[IMEM_AW+1:2];
                retired_d = retired_inc;
                if (retired_inc != target_q) begin
                    if (addr_misaligned) begin
                        err_code_d = ErrMisalign;
                    end else if (addr_oor) begin
                        err_code_d = ErrRange;
                    end
                end
            end else if (expired) begin
                err_code_d = ErrTimeout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            inst_q     <= '0;
            retired_q  <= '0;
            target_q   <= '0;
            err_code_q <= ErrNone;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            retired_q  <= retired_d;
            target_q   <= target_d;
            err_code_q <= err_code_d;
        end
    end

    // Outputs decoded from the registered state, so they drop as soon as reset asserts
    always_comb begin
        imem_rd_o   = (state_q == StFetch);
        imem_addr_o = (state_q == StFetch) ? pc_q : '0;
        in_valid_o  = (state_q == StIssue);
        inst_o      = (state_q == StIssue) ? inst_q : '0;
        busy_o      = (state_q == StFetch) || (state_q == StLoad) ||
                      (state_q == StIssue) || (state_q == StWait);
        done_o      = (state_q == StDone);
        err_o       = (state_q == StErr);
        err_code_o  = err_code_q;
        retired_o   = retired_q;
    end

endmodule
